fmul_issue_ctrl: RTL and testbench

- Operand-issue and result-capture controller placed directly upstream of the floating-point multiplier datapath.
- Accepts operand pairs on a valid/ready handshake and holds them stable for the multiplier's multi-cycle run.
- Pulses the multiplier start/load strobe, counts the fixed multiplier latency, then captures the 32-bit product.
- Presents the product with its tag on a valid/ready output handshake, buffering one result so the next operation can start while the result waits.

---
 rtl/fmul_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_fmul_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_issue_ctrl.sv
// Issue/capture controller in front of a multi-cycle FP multiplier: latches operands,
// pulses start, waits out the fixed latency and buffers one tagged product.
module fmul_issue_ctrl #(
  parameter int unsigned LATENCY = 36,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [31:0]      i_op_a,
  input  logic [31:0]      i_op_b,
  input  logic [TAG_W-1:0] i_op_tag,
  output logic [31:0]      o_mul_a,
  output logic [31:0]      o_mul_b,
  output logic             o_mul_start,
  input  logic [31:0]      i_mul_res,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [31:0]      o_res,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic [TAG_W-1:0] r_pend_tag;
  logic [31:0]      r_mul_a;
  logic [31:0]      r_mul_b;
  logic             r_mul_start;
  logic [31:0]      r_res;
  logic [TAG_W-1:0] r_res_tag;
  logic             r_res_valid;
  logic             w_accept;
  logic             w_capture;

  // Next-state, counter and accept/capture decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_op_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        w_cnt_nxt   = LAT_M1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Output slot is free, or is being emptied this very cycle
        if (!r_res_valid || i_res_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and latency counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operand hold, start strobe and one-deep result buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mul_a     <= 32'd0;
      r_mul_b     <= 32'd0;
      r_pend_tag  <= '0;
      r_mul_start <= 1'b0;
      r_res       <= 32'd0;
      r_res_tag   <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_mul_start <= w_accept;
      if (w_accept) begin
        r_mul_a    <= i_op_a;
        r_mul_b    <= i_op_b;
        r_pend_tag <= i_op_tag;
      end
      if (w_capture) begin
        r_res       <= i_mul_res;
        r_res_tag   <= r_pend_tag;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && i_res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_op_ready  = (r_state == IDLE);
  assign o_busy      = (r_state != IDLE);
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_mul_start = r_mul_start;
  assign o_res       = r_res;
  assign o_res_tag   = r_res_tag;
  assign o_res_valid = r_res_valid;

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Directed/random bench for fmul_issue_ctrl with a latency-accurate multiplier model
// and an in-order result scoreboard.
module tb_fmul_issue_ctrl;
  localparam int L = 36;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_op_valid = 1'b0;
  logic        o_op_ready;
  logic [31:0] i_op_a = 32'd0, i_op_b = 32'd0;
  logic [3:0]  i_op_tag = 4'd0;
  logic [31:0] o_mul_a, o_mul_b;
  logic        o_mul_start;
  logic [31:0] i_mul_res = 32'hDEADBEEF;
  logic        o_res_valid;
  logic        i_res_ready = 1'b0;
  logic [31:0] o_res;
  logic [3:0]  o_res_tag;
  logic        o_busy;

  logic        b_op_valid = 1'b0, b_op_ready, b_mul_start, b_res_valid, b_busy;
  logic [31:0] b_mul_a, b_mul_b, b_mul_res, b_res;
  logic [3:0]  b_res_tag;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mcnt = 0;
  logic [35:0] sb_q[$];

  always #5 clk = ~clk;

  fmul_issue_ctrl #(.LATENCY(L), .TAG_W(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_op_valid(i_op_valid), .o_op_ready(o_op_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_op_tag(i_op_tag),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .o_mul_start(o_mul_start),
    .i_mul_res(i_mul_res), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res(o_res), .o_res_tag(o_res_tag), .o_busy(o_busy));

  fmul_issue_ctrl #(.LATENCY(2), .TAG_W(4)) dut2 (
    .i_clk(clk), .i_rst(i_rst), .i_op_valid(b_op_valid), .o_op_ready(b_op_ready),
    .i_op_a(32'h40000000), .i_op_b(32'h40400000), .i_op_tag(4'd5),
    .o_mul_a(b_mul_a), .o_mul_b(b_mul_b), .o_mul_start(b_mul_start),
    .i_mul_res(b_mul_res), .o_res_valid(b_res_valid), .i_res_ready(1'b1),
    .o_res(b_res), .o_res_tag(b_res_tag), .o_busy(b_busy));

  // Truncating single-precision multiply for normal operands
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    logic [22:0] f;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (p[47]) begin
      e = a[30:23] + b[30:23] - 8'd126;
      f = p[46:24];
    end else begin
      e = a[30:23] + b[30:23] - 8'd127;
      f = p[45:23];
    end
    return {a[31] ^ b[31], e, f};
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  assign b_mul_res = fmul(b_mul_a, b_mul_b);

  // Multiplier model: product valid L cycles after the start strobe ends, garbage before
  always @(posedge clk) begin
    if (i_rst) begin
      mcnt = 0;
      i_mul_res <= 32'hDEADBEEF;
    end else if (o_mul_start) begin
      mcnt = L;
      i_mul_res <= 32'hDEADBEEF;
    end else if (mcnt > 1) begin
      mcnt = mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt = 0;
      i_mul_res <= fmul(o_mul_a, o_mul_b);
    end
  end

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    i_op_a = a; i_op_b = b; i_op_tag = tag; i_op_valid = 1'b1;
    sb_q.push_back({tag, fmul(a, b)});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_op_ready && n < 200) begin tick(); n++; end
    chk1("op_ready_timeout", o_op_ready, 1'b1);
  endtask

  // Scoreboard: every output transfer must match the oldest outstanding op
  always @(negedge clk) begin
    if (!i_rst && o_res_valid && i_res_ready) begin
      chk1("sb_nonempty", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        logic [35:0] e;
        e = sb_q.pop_front();
        chk32("sb_res", o_res, e[31:0]);
        chk32("sb_tag", {28'd0, o_res_tag}, {28'd0, e[35:32]});
      end
    end
  end

  initial begin
    int starts;
    int last_acc;
    int n;
    logic [31:0] ha, hb;

    repeat (3) tick();
    chk32("rst_mul_a", o_mul_a, 32'd0);
    chk32("rst_res", o_res, 32'd0);
    chk1("rst_res_valid", o_res_valid, 1'b0);
    chk1("rst_start", o_mul_start, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_ready", o_op_ready, 1'b1);
    i_rst = 1'b0;
    tick();

    // LATENCY=2 instance: accept at T, result valid exactly at T+5
    b_op_valid = 1'b1;
    tick();
    b_op_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk1("lat2_valid", b_res_valid, k == 5);
      if (k == 5) chk32("lat2_res", b_res, 32'h40C00000);
      tick();
    end

    // Single op with exact latency
    i_res_ready = 1'b1;
    chk1("single_ready", o_op_ready, 1'b1);
    issue(32'h40000000, 32'h40400000, 4'd3);
    tick();
    i_op_valid = 1'b0;
    chk1("single_start", o_mul_start, 1'b1);
    for (int k = 2; k <= L + 4; k++) begin
      tick();
      chk1("single_start_once", o_mul_start, 1'b0);
      chk1("single_valid", o_res_valid, k == L + 3);
      if (k == L + 3) begin
        chk32("single_res", o_res, 32'h40C00000);
        chk32("single_tag", {28'd0, o_res_tag}, 32'd3);
      end
    end

    // Backpressure: second op stalls in DONE, capture overlaps the transfer
    i_res_ready = 1'b0;
    wait_ready();
    issue(32'h3FC00000, 32'h40000000, 4'd1);
    tick();
    i_op_valid = 1'b0;
    n = 0;
    while (!o_res_valid && n < L + 10) begin tick(); n++; end
    chk1("bp_first_valid", o_res_valid, 1'b1);
    chk32("bp_first_res", o_res, 32'h40400000);
    wait_ready();
    issue(32'h40400000, 32'h40400000, 4'd2);
    tick();
    i_op_valid = 1'b0;
    for (int k = 0; k < L + 4; k++) begin
      tick();
      chk32("bp_hold_res", o_res, 32'h40400000);
    end
    chk1("bp_stall_ready", o_op_ready, 1'b0);
    chk1("bp_stall_busy", o_busy, 1'b1);
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk1("bp_no_bubble", o_res_valid, 1'b1);
    chk32("bp_second_res", o_res, 32'h41100000);
    chk32("bp_second_tag", {28'd0, o_res_tag}, 32'd2);
    chk1("bp_idle_after", o_op_ready, 1'b1);
    i_res_ready = 1'b1;
    tick();
    chk1("bp_drained", o_res_valid, 1'b0);

    // Operand hold under input churn
    issue(32'h40A00000, 32'h3F800000, 4'd7);
    ha = 32'h40A00000; hb = 32'h3F800000;
    tick();
    starts = 0;
    for (int k = 1; k <= L + 2; k++) begin
      if (o_mul_start) starts++;
      i_op_a = $urandom; i_op_b = $urandom; i_op_valid = 1'b1;
      chk32("hold_a", o_mul_a, ha);
      chk32("hold_b", o_mul_b, hb);
      tick();
    end
    i_op_valid = 1'b0;
    chk32("hold_one_start", starts, 32'd1);
    chk1("hold_res_valid", o_res_valid, 1'b1);
    tick();

    // Reset in RUN with counter at 10
    issue(32'h40400000, 32'h40000000, 4'd9);
    tick();
    i_op_valid = 1'b0;
    repeat (L - 10) tick();
    i_rst = 1'b1;
    void'(sb_q.pop_back());
    tick();
    i_rst = 1'b0;
    chk32("rstrun_mul_a", o_mul_a, 32'd0);
    chk32("rstrun_mul_b", o_mul_b, 32'd0);
    chk32("rstrun_res", o_res, 32'd0);
    chk32("rstrun_tag", {28'd0, o_res_tag}, 32'd0);
    chk1("rstrun_valid", o_res_valid, 1'b0);
    chk1("rstrun_start", o_mul_start, 1'b0);
    chk1("rstrun_idle", o_op_ready, 1'b1);
    starts = 0;
    for (int k = 0; k < L + 10; k++) begin
      if (o_mul_start || o_res_valid) starts++;
      tick();
    end
    chk32("rstrun_quiet", starts, 32'd0);

    // Back-to-back stream with random tags and random backpressure
    last_acc = 0;
    for (int op = 0; op < 8; op++) begin
      n = 0;
      while (!o_op_ready && n < 400) begin
        i_res_ready = 1'($urandom);
        tick();
        n++;
      end
      chk1("stream_ready", o_op_ready, 1'b1);
      issue(rnd_op(), rnd_op(), 4'($urandom));
      if (op > 0) chk1("stream_gap", (cyc - last_acc) >= L + 3, 1'b1);
      last_acc = cyc;
      i_res_ready = 1'($urandom);
      tick();
      i_op_valid = 1'b0;
    end
    i_res_ready = 1'b1;
    n = 0;
    while ((sb_q.size() > 0 || o_res_valid) && n < 400) begin tick(); n++; end
    chk32("stream_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
